ebc_hier_event_arbiter: RTL and testbench

Two-level round-robin event arbiter for the 8x8 EBC pixel array, organised as 4x4 groups of 2x2 pixels. It picks a group with pending events, then serves every pending pixel inside that group, one at a time. Each served pixel becomes a 39-bit event packet {timestamp, row, col, polarity}, emitted on a valid/ready stream toward the event FIFO/readout. The block sits between the pixel request array and the readout.

---
 rtl/lib_arbiter_pkg.sv | 37 +++
 rtl/ebc_hier_event_arbiter_rr_arbiter.sv | 22 ++
 rtl/ebc_hier_event_arbiter.sv | 113 +++++++++++
 tb/tb_ebc_hier_event_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/lib_arbiter_pkg.sv
// lib_arbiter_pkg: shared geometry, packet layout and FSM states for the EBC hierarchical event arbiter
package lib_arbiter_pkg;

    localparam int ROWS          = 8;
    localparam int COLS          = 8;
    localparam int LVL0_ROWS     = 2;
    localparam int LVL_ROWS      = 4;
    localparam int SIZE          = 32;
    localparam int ROW_ADD       = 3;
    localparam int COL_ADD       = 3;
    localparam int WIDTH         = SIZE + ROW_ADD + COL_ADD + 1;
    localparam int NUM_GROUPS    = 16;
    localparam int PIX_PER_GROUP = 4;
    localparam int TS_LSB        = 7;
    localparam int ROW_LSB       = 4;
    localparam int COL_LSB       = 1;
    localparam int POL_BIT       = 0;

    typedef enum logic [1:0] {IDLE, PIX, SEND} state_e;

    // Linear pixel number (row*COLS+col) from group coordinates and sub-pixel coordinates
    function automatic int pix_num(input int grow, input int gcol, input int sr, input int sc);
        return (grow * LVL0_ROWS + sr) * COLS + gcol * LVL0_ROWS + sc;
    endfunction

    function automatic logic [WIDTH-1:0] make_pkt(input logic [SIZE-1:0] ts, input logic [ROW_ADD-1:0] row,
                                                  input logic [COL_ADD-1:0] col, input logic pol);
        logic [WIDTH-1:0] pkt;
        pkt = '0;
        pkt[TS_LSB +: SIZE]     = ts;
        pkt[ROW_LSB +: ROW_ADD] = row;
        pkt[COL_LSB +: COL_ADD] = col;
        pkt[POL_BIT]            = pol;
        return pkt;
    endfunction

endpackage

// File: rtl/ebc_hier_event_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker, search starts at ptr+1 and wraps mod N
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [N-1:0] gnt_o,
    output logic [W-1:0] index_o,
    output logic         any_o
);

    // Scan offsets from farthest to nearest so the nearest requester after ptr wins
    always_comb begin
        index_o = '0;
        for (int k = N; k >= 1; k--)
            if (req_i[(int'(ptr_i) + k) % N]) index_o = W'((int'(ptr_i) + k) % N);
        any_o = |req_i;
        gnt_o = any_o ? (N'(1) << index_o) : '0;
    end

endmodule

// File: rtl/ebc_hier_event_arbiter.sv
// ebc_hier_event_arbiter: two-level round-robin arbiter turning 8x8 pixel requests into timestamped event packets
module ebc_hier_event_arbiter
    import lib_arbiter_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [ROWS*COLS*2-1:0]   pix_pol_i,
    output logic [ROWS*COLS-1:0]     pix_ack_o,
    output logic [WIDTH-1:0]         evt_data_o,
    output logic                     evt_valid_o,
    input  logic                     evt_ready_i,
    output logic                     busy_o
);

    state_e            state_q, state_d;
    logic [SIZE-1:0]   ts_q;
    logic [3:0]        gptr_q, gptr_d, grp_q, grp_d;
    logic [1:0]        pptr_q, pptr_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [NUM_GROUPS-1:0]    grp_req, grp_gnt_unused;
    logic [PIX_PER_GROUP-1:0] pix_req, pix_on, pix_gnt;
    logic [3:0]        grp_idx;
    logic [1:0]        pix_idx;
    logic              grp_any, pix_any;

    // Group requests from every pixel, plus live requests/polarity of the latched group
    always_comb begin
        grp_req = '0;
        pix_req = '0;
        pix_on  = '0;
        for (int gr = 0; gr < LVL_ROWS; gr++)
            for (int gc = 0; gc < LVL_ROWS; gc++)
                for (int sr = 0; sr < LVL0_ROWS; sr++)
                    for (int sc = 0; sc < LVL0_ROWS; sc++)
                        grp_req[gr*LVL_ROWS+gc] = grp_req[gr*LVL_ROWS+gc] | (|pix_pol_i[2*pix_num(gr, gc, sr, sc) +: 2]);
        for (int sr = 0; sr < LVL0_ROWS; sr++)
            for (int sc = 0; sc < LVL0_ROWS; sc++) begin
                pix_req[sr*LVL0_ROWS+sc] = |pix_pol_i[2*pix_num(int'(grp_q[3:2]), int'(grp_q[1:0]), sr, sc) +: 2];
                pix_on[sr*LVL0_ROWS+sc]  = pix_pol_i[2*pix_num(int'(grp_q[3:2]), int'(grp_q[1:0]), sr, sc) + 1];
            end
    end

    rr_arbiter #(.N(NUM_GROUPS)) u_grp_arb (
        .req_i   (grp_req),
        .ptr_i   (gptr_q),
        .gnt_o   (grp_gnt_unused),
        .index_o (grp_idx),
        .any_o   (grp_any)
    );

    rr_arbiter #(.N(PIX_PER_GROUP)) u_pix_arb (
        .req_i   (pix_req),
        .ptr_i   (pptr_q),
        .gnt_o   (pix_gnt),
        .index_o (pix_idx),
        .any_o   (pix_any)
    );

    // Next state: hold a group until it empties, serving one pixel per PIX/SEND pair
    always_comb begin
        state_d = state_q;
        gptr_d  = gptr_q;
        pptr_d  = pptr_q;
        grp_d   = grp_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: if (grp_any) begin
                grp_d   = grp_idx;
                state_d = PIX;
            end
            PIX: if (!pix_any) begin
                gptr_d  = grp_q;
                state_d = IDLE;
            end else begin
                data_d  = make_pkt(ts_q, {grp_q[3:2], pix_idx[1]}, {grp_q[1:0], pix_idx[0]}, |(pix_gnt & pix_on));
                pptr_d  = pix_idx;
                state_d = SEND;
            end
            SEND: state_d = evt_ready_i ? PIX : SEND;
            default: state_d = IDLE;
        endcase
    end

    // FSM, pointers and packet register; reset priorities group 0 / sub-pixel 0
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
            gptr_q  <= 4'd15;
            pptr_q  <= 2'd3;
            grp_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            gptr_q  <= gptr_d;
            pptr_q  <= pptr_d;
            grp_q   <= grp_d;
            data_q  <= data_d;
        end
    end

    // Free-running timestamp, wraps naturally
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) ts_q <= '0;
        else          ts_q <= ts_q + 1'b1;
    end

    assign evt_valid_o = state_q == SEND;
    assign busy_o      = state_q != IDLE;
    assign evt_data_o  = data_q;
    assign pix_ack_o   = (evt_valid_o && evt_ready_i) ?
                         (ROWS*COLS)'(1) << {data_q[ROW_LSB +: ROW_ADD], data_q[COL_LSB +: COL_ADD]} : '0;

endmodule

// File: tb/tb_ebc_hier_event_arbiter.sv
// tb_ebc_hier_event_arbiter: directed stimulus with a scoreboard queue checked by an independent monitor
module tb_ebc_hier_event_arbiter;

    logic         clk_i = 1'b0;
    logic         reset_i = 1'b0;
    logic         evt_ready_i = 1'b0;
    logic [127:0] pix_pol_i = '0;
    logic [63:0]  pix_ack_o;
    logic [38:0]  evt_data_o;
    logic         evt_valid_o;
    logic         busy_o;

    typedef struct {
        logic [38:0] data;
        int          pix;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] tcnt;
    logic [31:0] t;
    bit          rearm = 1'b0;
    logic [63:0] ack_h1 = '0;
    logic [63:0] ack_h2 = '0;

    always #5 clk_i = ~clk_i;

    ebc_hier_event_arbiter dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .pix_pol_i   (pix_pol_i),
        .pix_ack_o   (pix_ack_o),
        .evt_data_o  (evt_data_o),
        .evt_valid_o (evt_valid_o),
        .evt_ready_i (evt_ready_i),
        .busy_o      (busy_o)
    );

    // Reference cycle counter: value seen by the arbiter in the current cycle
    always @(posedge clk_i or negedge reset_i)
        if (!reset_i) tcnt <= '0;
        else          tcnt <= tcnt + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every handshake must match the head of the scoreboard, no ack otherwise
    always @(negedge clk_i) begin
        #3;
        if (reset_i) begin
            if (evt_valid_o && evt_ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pkt: got %h expected none", evt_data_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("pkt_data", {25'd0, evt_data_o}, {25'd0, mon_e.data});
                    chk("pkt_ack", pix_ack_o, 64'd1 << mon_e.pix);
                end
            end else chk("idle_ack", pix_ack_o, '0);
        end
    end

    task automatic set_pix(input int r, input int c, input logic [1:0] v);
        pix_pol_i[2*(r*8+c) +: 2] = v;
    endtask

    task automatic expect_pkt(input logic [31:0] ts, input int r, input int c, input logic pol);
        exp_t e;
        e.data = {ts, 3'(r), 3'(c), pol};
        e.pix  = r * 8 + c;
        exp_q.push_back(e);
    endtask

    // One cycle: pixels drop requests on the edge where they were acked; optional re-arm 2 cycles later
    task automatic tick();
        logic [63:0] a;
        #1 a = pix_ack_o;
        @(posedge clk_i);
        #1;
        for (int n = 0; n < 64; n++) if (a[n]) pix_pol_i[2*n +: 2] = 2'b00;
        ack_h2 = ack_h1;
        ack_h1 = a;
        @(negedge clk_i);
        if (rearm) for (int n = 0; n < 64; n++) if (ack_h2[n]) pix_pol_i[2*n +: 2] = 2'b10;
    endtask

    task automatic do_reset();
        reset_i     = 1'b0;
        pix_pol_i   = '0;
        evt_ready_i = 1'b1;
        rearm       = 1'b0;
        ack_h1      = '0;
        ack_h2      = '0;
        exp_q.delete();
        repeat (2) @(negedge clk_i);
        reset_i = 1'b1;
    endtask

    initial begin
        // Reset state
        do_reset();
        reset_i = 1'b0;
        #1;
        chk("rst_valid", {63'd0, evt_valid_o}, 0);
        chk("rst_data", {25'd0, evt_data_o}, 0);
        chk("rst_ack", pix_ack_o, 0);
        chk("rst_busy", {63'd0, busy_o}, 0);

        // Single event: row5/col6, ON
        do_reset();
        t = tcnt;
        set_pix(5, 6, 2'b10);
        expect_pkt(t + 1, 5, 6, 1'b1);
        tick();
        chk("t1_pix_busy", {63'd0, busy_o}, 1);
        chk("t1_pix_novalid", {63'd0, evt_valid_o}, 0);
        tick();
        chk("t1_valid_c2", {63'd0, evt_valid_o}, 1);
        chk("t1_ack_c2", pix_ack_o, 64'd1 << 46);
        tick();
        chk("t1_back_pix", {62'd0, busy_o, evt_valid_o}, 2);
        tick();
        chk("t1_idle", {63'd0, busy_o}, 0);
        chk("t1_drain", 64'(exp_q.size()), 0);

        // Intra-group order: all of group 0 OFF
        do_reset();
        t = tcnt;
        set_pix(0, 0, 2'b01);
        set_pix(0, 1, 2'b01);
        set_pix(1, 0, 2'b01);
        set_pix(1, 1, 2'b01);
        expect_pkt(t + 1, 0, 0, 1'b0);
        expect_pkt(t + 3, 0, 1, 1'b0);
        expect_pkt(t + 5, 1, 0, 1'b0);
        expect_pkt(t + 7, 1, 1, 1'b0);
        repeat (10) tick();
        chk("t2_drain", 64'(exp_q.size()), 0);
        chk("t2_idle", {63'd0, busy_o}, 0);

        // Group fairness: groups 3 and 12 keep re-requesting
        do_reset();
        t = tcnt;
        set_pix(0, 6, 2'b10);
        set_pix(6, 0, 2'b10);
        rearm = 1'b1;
        expect_pkt(t + 1, 0, 6, 1'b1);
        expect_pkt(t + 5, 6, 0, 1'b1);
        expect_pkt(t + 9, 0, 6, 1'b1);
        expect_pkt(t + 13, 6, 0, 1'b1);
        expect_pkt(t + 17, 0, 6, 1'b1);
        repeat (18) tick();
        rearm     = 1'b0;
        pix_pol_i = '0;
        repeat (4) tick();
        chk("t3_drain", 64'(exp_q.size()), 0);
        chk("t3_idle", {63'd0, busy_o}, 0);

        // Backpressure: 10 stalled cycles in SEND
        do_reset();
        evt_ready_i = 1'b0;
        t = tcnt;
        set_pix(3, 4, 2'b11);
        expect_pkt(t + 1, 3, 4, 1'b1);
        tick();
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("t4_stall_valid", {63'd0, evt_valid_o}, 1);
            chk("t4_stall_ack", pix_ack_o, 0);
            chk("t4_stall_data", {25'd0, evt_data_o}, {25'd0, t + 32'd1, 3'd3, 3'd4, 1'b1});
            tick();
        end
        evt_ready_i = 1'b1;
        #1 chk("t4_ack_same_cycle", pix_ack_o, 64'd1 << 28);
        tick();
        tick();
        chk("t4_drain", 64'(exp_q.size()), 0);

        // Withdrawn request in group 5, then pointer effect on groups 0 and 6
        do_reset();
        set_pix(2, 2, 2'b10);
        tick();
        set_pix(2, 2, 2'b00);
        tick();
        chk("t5_idle", {62'd0, busy_o, evt_valid_o}, 0);
        tick();
        chk("t5_still_idle", {63'd0, busy_o}, 0);
        t = tcnt;
        set_pix(0, 0, 2'b10);
        set_pix(2, 4, 2'b01);
        expect_pkt(t + 1, 2, 4, 1'b0);
        expect_pkt(t + 5, 0, 0, 1'b1);
        repeat (8) tick();
        chk("t5_drain", 64'(exp_q.size()), 0);

        // Reset during SEND
        do_reset();
        evt_ready_i = 1'b0;
        set_pix(7, 7, 2'b10);
        tick();
        tick();
        chk("t6_in_send", {63'd0, evt_valid_o}, 1);
        evt_ready_i = 1'b1;
        reset_i     = 1'b0;
        #1;
        chk("t6_rst_valid", {63'd0, evt_valid_o}, 0);
        chk("t6_rst_ack", pix_ack_o, 0);
        chk("t6_rst_data", {25'd0, evt_data_o}, 0);
        chk("t6_rst_busy", {63'd0, busy_o}, 0);

        // Timestamp wrap
        do_reset();
        force dut.ts_q = 32'hFFFF_FFFE;
        #1 release dut.ts_q;
        tick();
        set_pix(4, 1, 2'b10);
        expect_pkt(32'h0000_0000, 4, 1, 1'b1);
        repeat (4) tick();
        chk("t6_wrap_drain", 64'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
